// File: rtl/rgb_pwm_seq.sv
// Three-channel breathing PWM sequencer for the SB_RGBA_DRV RGBxPWM inputs.
// Define RGB_PWM_GAMMA_EN to square the duty value before it reaches the comparator.
module rgb_pwm_seq #(
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    output logic       rgb0_pwm,
    output logic       rgb1_pwm,
    output logic       rgb2_pwm,
    output logic [1:0] chan,
    output logic       busy,
    output logic       cycle_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic [PWM_BITS-1:0] MAX = '1;

    state_t                   state;
    state_t                   state_nxt;
    logic [PWM_BITS-1:0]      pwm_ctr;
    logic [PRESCALE_BITS-1:0] pre_ctr;
    logic [PWM_BITS-1:0]      duty;
    logic [PWM_BITS-1:0]      duty_nxt;
    logic [PWM_BITS-1:0]      duty_sh;
    logic [PWM_BITS-1:0]      duty_eff;
    logic [1:0]               chan_nxt;
    logic                     wrap;
    logic                     tick;

    assign tick = (pre_ctr == '1);

`ifdef RGB_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;

    // Squaring the ramp makes perceived brightness change roughly linearly.
    assign duty_sq  = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
    assign duty_eff = PWM_BITS'(duty_sq >> PWM_BITS);
`else
    assign duty_eff = duty;
`endif

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        chan_nxt  = chan;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = UP;
                duty_nxt  = '0;
                chan_nxt  = 2'd0;
            end
            UP: begin
                if (tick) begin
                    if (duty == MAX) state_nxt = DOWN;
                    else             duty_nxt  = duty + 1'b1;
                end
            end
            DOWN: begin
                if (tick) begin
                    if (duty == '0) begin
                        state_nxt = UP;
                        if (chan == 2'd2) begin
                            chan_nxt = 2'd0;
                            wrap     = 1'b1;
                        end else begin
                            chan_nxt = chan + 2'd1;
                        end
                    end else begin
                        duty_nxt = duty - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Dropping enable always wins and restarts the pattern from scratch.
        if (!en) begin
            state_nxt = IDLE;
            duty_nxt  = '0;
            chan_nxt  = 2'd0;
            wrap      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            duty       <= '0;
            chan       <= 2'd0;
            cycle_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            duty       <= duty_nxt;
            chan       <= chan_nxt;
            cycle_done <= wrap;
            busy       <= (state_nxt != IDLE);
        end
    end

    // The shadow only reloads at the end of a PWM period, so each period uses one duty.
    always_ff @(posedge clk) begin
        if (!rstn || state == IDLE || state_nxt == IDLE) begin
            pwm_ctr  <= '0;
            pre_ctr  <= '0;
            duty_sh  <= '0;
            rgb0_pwm <= 1'b0;
            rgb1_pwm <= 1'b0;
            rgb2_pwm <= 1'b0;
        end else begin
            pwm_ctr  <= pwm_ctr + 1'b1;
            pre_ctr  <= pre_ctr + 1'b1;
            if (pwm_ctr == MAX) duty_sh <= duty_eff;
            rgb0_pwm <= (chan == 2'd0) && (pwm_ctr < duty_sh);
            rgb1_pwm <= (chan == 2'd1) && (pwm_ctr < duty_sh);
            rgb2_pwm <= (chan == 2'd2) && (pwm_ctr < duty_sh);
        end
    end

endmodule

// File: doc/rgb_pwm_seq.md
# rgb_pwm_seq

Three-channel PWM colour sequencer that drives the `RGB0PWM`/`RGB1PWM`/`RGB2PWM` inputs of the SB_RGBA_DRV LED driver. It replaces the raw counter-bit decode used for LED blinking. It produces a "breathing" pattern: each channel ramps its duty cycle up, then back down, and the sequencer then moves to the next channel. All logic runs on the single fabric clock (HFOSC or PLL output). The block also acts as a controllable switching-activity load for power measurements.

## Interface
- `PWM_BITS`, default 8: PWM counter and duty width; MAX = 2^PWM_BITS-1.
- `PRESCALE_BITS`, default 16: prescaler width; one ramp tick every 2^PRESCALE_BITS clocks.
- `clk`  in  1  fabric clock; all logic on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `en`  in  1  run enable; low forces IDLE.
- `rgb0_pwm`  out  1  channel 0 PWM (to RGB0PWM).
- `rgb1_pwm`  out  1  channel 1 PWM (to RGB1PWM).
- `rgb2_pwm`  out  1  channel 2 PWM (to RGB2PWM).
- `chan`  out  2  active channel index, 0..2.
- `busy`  out  1  high when state != IDLE.
- `cycle_done`  out  1  one-cycle pulse when the channel index wraps from 2 to 0.

## Operation
- States: IDLE, UP, DOWN.
- Registers: `pwm_ctr` (PWM_BITS wide), `pre_ctr` (PRESCALE_BITS wide), `duty` (PWM_BITS wide), `duty_sh` (PWM_BITS wide), `chan` (2 bits).
- IDLE behaviour:
  - `pwm_ctr`, `pre_ctr`, `duty` and `duty_sh` are held at 0; `chan` = 0.
  - IDLE -> UP when `en` = 1.
- UP/DOWN counters:
  - `pwm_ctr` increments every clock and wraps MAX -> 0.
  - `pre_ctr` increments every clock.
  - `tick` = (`pre_ctr` == all-ones).
- UP:
  - On `tick` with `duty` < MAX: `duty`++.
  - On `tick` with `duty` == MAX: -> DOWN, `duty` unchanged.
- DOWN:
  - On `tick` with `duty` > 0: `duty`--.
  - On `tick` with `duty` == 0: -> UP and `chan` advances.
  - Channel advance: if `chan` == 2, `chan` becomes 0 and `cycle_done` pulses high for the next cycle; otherwise `chan`++.
- Duty shadowing (glitch-free period updates):
  - `duty_sh` <= eff(`duty`) when `pwm_ctr` == MAX.
  - If a `tick` coincides, `duty_sh` captures the pre-update `duty`.
- Outputs:
  - Selected channel output <= (`pwm_ctr` < `duty_sh`); the other two outputs are 0.
  - `duty_sh` = 0 gives constant low.
  - `duty_sh` = MAX gives high for MAX of every 2^PWM_BITS cycles.
- Boundary conditions:
  - `en` deasserted in any state: next state is IDLE, all counters clear, all PWM outputs 0 on the next cycle. Re-enabling restarts at `chan` 0, `duty` 0.
  - `rstn` low mid-ramp has the same effect as `en` low, regardless of `en`.

## Timing
- Reset values: `rgb0_pwm`, `rgb1_pwm`, `rgb2_pwm`, `chan`, `busy` and `cycle_done` are all 0.
- All outputs are registered with no combinational input-to-output path.
- `busy` rises one clock after `en` is sampled high and falls one clock after `en` is sampled low.
- PWM output latency: the output reflects the `pwm_ctr`/`duty_sh` compare of the previous cycle (1 clock).
- Tick schedule: with cycle 0 as the first UP cycle, ticks occur at cycles 2^PRESCALE_BITS·n − 1 for n = 1, 2, ...
- Each channel takes 2·(MAX+1) ticks (UP: MAX increments plus one turnaround tick; DOWN: the same). A full 3-channel cycle takes 6·(MAX+1) ticks.

## Configuration
- `RGB_PWM_GAMMA_EN` defined: eff(d) = (d·d) >> PWM_BITS, using a PWM_BITS×PWM_BITS multiplier. This gives a perceptually linear ramp.
- `RGB_PWM_GAMMA_EN` undefined: eff(d) = d, and no multiplier is instantiated.
- The macro does not change the state machine or tick timing.

## Test plan
All scenarios use PWM_BITS=4 and PRESCALE_BITS=2 (MAX=15, tick every 4 clocks).
- Reset then `en`=1: `busy`=1 one clock later, `chan`=0. `duty` reaches 15 after 15 ticks (cycle 59). UP->DOWN at the 16th tick (cycle 63).
- Full sequence with `en` held: `chan` steps 0->1 at cycle 128 and 1->2 at cycle 256. `cycle_done` is high only in cycle 384, and `chan` is 0 in that cycle.
- PWM shape with gamma off and `duty_sh`=5: the active output is high for exactly 5 of every 16 clocks. The other two outputs stay 0. `duty_sh`=0 gives the output constantly low.
- Duty shadow coincidence: force a `tick` on the same cycle as `pwm_ctr`=15. `duty_sh` takes the pre-increment `duty` value, and no period shows a mixed duty.
- `en` dropped mid-DOWN on `chan` 1: next cycle all outputs are 0, `busy`=0 and `chan`=0. Re-enable restarts at `chan` 0 with `duty` 0.
- `RGB_PWM_GAMMA_EN` defined: `duty`=15 gives `duty_sh`=14, `duty`=4 gives 1, and `duty`=3 gives 0. Without the macro, `duty`=15 gives `duty_sh`=15.
